el2_exu_div_receiver: RTL and testbench
=======================================

// Module: el2_exu_div_receiver
// PURPOSE
//  Divider-side NoC endpoint: reassembles divide-request packets from flits and presents them to el2_exu_div.
//  Request payload is {dp, cancel, dividend, divisor}; a header flit is followed by body flits.
//  Sits between the NoC output port at POS_DIV_WRAPPER and the divider's request inputs.
//  Holds one complete request until the divider accepts it.
// PARAMETERS
//  FLIT_DATA_BITS  32   payload bits per flit
//  PACKET_BITS     64   {dividend, divisor}
//  PADDING_BITS    4    {dp(3), cancel(1)}
//  ADDR_BITS       4    width of the dst field in the header flit
//  MY_ADDR         `POS_DIV_WRAPPER  accepted destination
// PORTS
//  clk            in   1   NoC clock
//  rst            in   1   synchronous reset, active-high
//  flit_valid     in   1   flit present
//  flit_head      in   1   flit is a header
//  flit_tail      in   1   flit is the last of its packet
//  flit_data      in   FLIT_DATA_BITS  flit payload
//  flit_ready     out  1   flit accepted when flit_valid&flit_ready
//  out_valid      out  1   request held for the divider
//  out_ready      in   1   divider takes the request
//  dp             out  el2_div_pkt_t  valid/unsign/rem (dp.valid = out_valid & stored valid bit)
//  cancel         out  1   cancel flag of held request
//  dividend       out  32
//  divisor        out  32
//  err            out  1   one-cycle pulse per dropped or malformed packet
// BEHAVIOUR
//  - Reset: state IDLE, flit_ready=0 during rst, out_valid=0, dp='0, cancel=0, dividend=0, divisor=0, err=0, beat counter=0.
//  - NB = ceil((PACKET_BITS+PADDING_BITS)/FLIT_DATA_BITS); NB=3 at defaults.
//  - Payload vector P = {padding, packet}. Body beat k carries P[k*FLIT_DATA_BITS +: FLIT_DATA_BITS], LSB chunk first.
//    Unused top bits of the last beat are ignored.
//  - The header carries no payload; header flit_data[ADDR_BITS-1:0] = dst.
//  - FSM:
//    IDLE: header accepted, dst==MY_ADDR -> BODY (cnt=0); dst!=MY_ADDR -> DROP, err.
//      Non-header flit -> consumed, err, stay IDLE.
//      A header that also carries tail -> err, stay IDLE.
//    BODY: each beat is stored at index cnt and cnt increments.
//      Tail with cnt==NB-1 -> DELIVER.
//      Tail with cnt<NB-1 -> IDLE, err, no delivery.
//      Beat NB-1 without tail -> DROP, err.
//      Header mid-packet -> err; the new header is processed as in IDLE (abort and restart).
//    DROP: consume flits; tail -> IDLE.
//    DELIVER: out_valid=1, outputs stable. out_ready -> IDLE, out_valid=0 next cycle.
//  - flit_ready = !rst & (state!=DELIVER | out_ready).
//    In DELIVER with out_ready=1, an incoming header is accepted in the same cycle; the next state follows the IDLE rules.
//  - Latency: tail accepted in cycle t -> out_valid=1 in t+1.
//    Back-to-back packets: one idle beat minimum between deliveries, set by the header flit.
//  - Outputs hold their last delivered values after the handoff; only out_valid and dp.valid drop.
//  - Reset in mid-operation: the partial packet is discarded; the remainder is consumed as ordinary flits (err pulses allowed).
//  - err is never asserted in two consecutive cycles for the same packet.
// STRUCTURE
//  - Shared package (noc_types): flit field typedef and a localparam function nb_flits(bits, flit_bits).
//  - el2_pkg: typedef el2_div_req_t = {el2_div_pkt_t dp; logic cancel; logic [31:0] dividend, divisor;}.
//  - Sub-module noc_serial_receiver (generic FSM plus beat shifter, parameters PACKET_BITS/PADDING_BITS).
//    It is the mirror of noc_serial_sender; this module only maps its outputs onto el2_div_req_t.
// TESTING
//  1. Reset, then header(dst=MY_ADDR) and 3 beats of {dp=3'b101,cancel=0,dividend=32'd100,divisor=32'd7}, tail on beat 3, out_ready=1
//     -> out_valid for exactly 1 cycle at t+1, dividend=100, divisor=7, dp.rem=1, err=0.
//  2. Same packet with out_ready=0 for 5 cycles -> out_valid held, flit_ready=0, a second header is stalled.
//     Raising out_ready accepts both in the same cycle.
//  3. header(dst=MY_ADDR+1) + 3 beats -> err pulse once, no out_valid, IDLE after tail.
//  4. header, 1 beat, then a new header -> err once; the second packet (dividend=32'hFFFF_FFFF, divisor=1, cancel=1) is delivered intact.
//  5. Tail on beat 2 -> err, no delivery. 4 beats with tail on beat 4 -> err at beat 3, no delivery.
//  6. Assert rst after beat 2 -> all outputs 0. The next complete packet is delivered correctly.

Source files
------------

// File: rtl/el2_exu_div_receiver_pkg.sv
// Shared types for the divider-side NoC receiver: divide request layout,
// flit fields, receiver FSM states and the beat-count helper.
package el2_exu_div_receiver_pkg;

  localparam logic [3:0] POS_DIV_WRAPPER    = 4'd5;
  localparam int         NOC_FLIT_DATA_BITS = 32;

  typedef struct packed {
    logic valid;
    logic unsign;
    logic rem;
  } el2_div_pkt_t;

  typedef struct packed {
    el2_div_pkt_t dp;
    logic         cancel;
    logic [31:0]  dividend;
    logic [31:0]  divisor;
  } el2_div_req_t;

  typedef struct packed {
    logic                          head;
    logic                          tail;
    logic [NOC_FLIT_DATA_BITS-1:0] data;
  } noc_flit_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_BODY,
    RX_DROP,
    RX_DELIVER
  } rx_state_e;

  function automatic int nb_flits(input int bits, input int flit_bits);
    return (bits + flit_bits - 1) / flit_bits;
  endfunction

endpackage

// File: rtl/el2_exu_div_receiver_noc_serial_receiver.sv
// Generic NoC packet reassembler: header/body FSM with a beat buffer and a
// held output payload that survives the handoff to the consumer.
module noc_serial_receiver
  import el2_exu_div_receiver_pkg::*;
#(
  parameter int                   FLIT_DATA_BITS = 32,
  parameter int                   PACKET_BITS    = 64,
  parameter int                   PADDING_BITS   = 4,
  parameter int                   ADDR_BITS      = 4,
  parameter logic [ADDR_BITS-1:0] MY_ADDR        = '0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flit_valid_i,
  input  logic                                  flit_head_i,
  input  logic                                  flit_tail_i,
  input  logic [FLIT_DATA_BITS-1:0]             flit_data_i,
  output logic                                  flit_ready_o,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [PACKET_BITS+PADDING_BITS-1:0]   payload_o,
  output logic                                  err_o
);

  localparam int PAYLOAD_BITS = PACKET_BITS + PADDING_BITS;
  localparam int NB           = nb_flits(PAYLOAD_BITS, FLIT_DATA_BITS);
  localparam int CNT_W        = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);

  rx_state_e                      state_q, state_d;
  rx_state_e                      hdr_state;
  logic                           hdr_err;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [NB*FLIT_DATA_BITS-1:0]   beats_q, beats_d;
  logic [PAYLOAD_BITS-1:0]        payload_q, payload_d;
  logic                           err_q, err_d;
  logic                           flit_accept;

  assign flit_ready_o = !rst_i && (state_q != RX_DELIVER || out_ready_i);
  assign flit_accept  = flit_valid_i && flit_ready_o;
  assign out_valid_o  = (state_q == RX_DELIVER);
  assign payload_o    = payload_q;
  assign err_o        = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      beats_q   <= '0;
      payload_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beats_q   <= beats_d;
      payload_q <= payload_d;
      err_q     <= err_d;
    end
  end

  // hdr_state/hdr_err give the outcome of an accepted flit under the idle rules,
  // reused when a header arrives mid-packet or during the delivery handoff.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beats_d   = beats_q;
    payload_d = payload_q;
    err_d     = 1'b0;
    hdr_state = RX_IDLE;
    hdr_err   = 1'b1;

    if (flit_head_i && !flit_tail_i) begin
      if (flit_data_i[ADDR_BITS-1:0] == MY_ADDR) begin
        hdr_state = RX_BODY;
        hdr_err   = 1'b0;
      end else begin
        hdr_state = RX_DROP;
      end
    end

    if (state_q == RX_DELIVER && out_ready_i) begin
      state_d = RX_IDLE;
    end

    if (flit_accept) begin
      case (state_q)
        RX_IDLE, RX_DELIVER: begin
          state_d = hdr_state;
          err_d   = hdr_err;
          cnt_d   = '0;
        end
        RX_BODY: begin
          if (flit_head_i) begin
            state_d = hdr_state;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            for (int k = 0; k < NB; k++) begin
              if (cnt_q == CNT_W'(k)) begin
                beats_d[k*FLIT_DATA_BITS +: FLIT_DATA_BITS] = flit_data_i;
              end
            end
            if (flit_tail_i) begin
              if (cnt_q == LAST_BEAT) begin
                state_d   = RX_DELIVER;
                payload_d = beats_d[PAYLOAD_BITS-1:0];
              end else begin
                state_d = RX_IDLE;
                err_d   = 1'b1;
              end
            end else if (cnt_q == LAST_BEAT) begin
              state_d = RX_DROP;
              err_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        RX_DROP: begin
          if (flit_tail_i) begin
            state_d = RX_IDLE;
          end
        end
        default: begin
          state_d = RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/el2_exu_div_receiver.sv
// Divider-side NoC endpoint: reassembles divide requests from flits and holds
// one complete request for el2_exu_div until it is accepted.
module el2_exu_div_receiver
  import el2_exu_div_receiver_pkg::*;
#(
  parameter int                   FLIT_DATA_BITS = NOC_FLIT_DATA_BITS,
  parameter int                   PACKET_BITS    = 64,
  parameter int                   PADDING_BITS   = 4,
  parameter int                   ADDR_BITS      = 4,
  parameter logic [ADDR_BITS-1:0] MY_ADDR        = POS_DIV_WRAPPER
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flit_valid_i,
  input  logic                      flit_head_i,
  input  logic                      flit_tail_i,
  input  logic [FLIT_DATA_BITS-1:0] flit_data_i,
  output logic                      flit_ready_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output el2_div_pkt_t              dp_o,
  output logic                      cancel_o,
  output logic [31:0]               dividend_o,
  output logic [31:0]               divisor_o,
  output logic                      err_o
);

  logic [PACKET_BITS+PADDING_BITS-1:0] payload;
  el2_div_req_t                        req;

  noc_serial_receiver #(
    .FLIT_DATA_BITS (FLIT_DATA_BITS),
    .PACKET_BITS    (PACKET_BITS),
    .PADDING_BITS   (PADDING_BITS),
    .ADDR_BITS      (ADDR_BITS),
    .MY_ADDR        (MY_ADDR)
  ) u_rx (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flit_valid_i (flit_valid_i),
    .flit_head_i  (flit_head_i),
    .flit_tail_i  (flit_tail_i),
    .flit_data_i  (flit_data_i),
    .flit_ready_o (flit_ready_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .payload_o    (payload),
    .err_o        (err_o)
  );

  assign req        = payload;
  assign cancel_o   = req.cancel;
  assign dividend_o = req.dividend;
  assign divisor_o  = req.divisor;

  // The stored fields stay visible after handoff; only the valid qualifier drops.
  always_comb begin
    dp_o       = req.dp;
    dp_o.valid = req.dp.valid & out_valid_o;
  end

endmodule

// File: tb/tb_el2_exu_div_receiver.sv
// Scoreboard bench for el2_exu_div_receiver: directed scenarios plus randomized
// packet mixes checked against a packet-level reference model.
module tb_el2_exu_div_receiver;
  import el2_exu_div_receiver_pkg::*;

  localparam logic [3:0] MY = POS_DIV_WRAPPER;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flitValid = 1'b0;
  logic         flitHead = 1'b0;
  logic         flitTail = 1'b0;
  logic [31:0]  flitData = '0;
  logic         outReady = 1'b0;
  logic         flitReady, outValid, cancelO, errO;
  el2_div_pkt_t dpO;
  logic [31:0]  dividendO, divisorO;
  logic [67:0]  bundle;

  int checks = 0;
  int errors = 0;
  int errSeen = 0;
  logic [67:0] expQ[$];
  bit outReadyRandom = 1'b0;
  bit gapRandom = 1'b0;

  el2_exu_div_receiver dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flit_valid_i (flitValid),
    .flit_head_i  (flitHead),
    .flit_tail_i  (flitTail),
    .flit_data_i  (flitData),
    .flit_ready_o (flitReady),
    .out_valid_o  (outValid),
    .out_ready_i  (outReady),
    .dp_o         (dpO),
    .cancel_o     (cancelO),
    .dividend_o   (dividendO),
    .divisor_o    (divisorO),
    .err_o        (errO)
  );

  always #5 clk = ~clk;

  assign bundle = {dpO, cancelO, dividendO, divisorO};

  task automatic checkOutput(input string name, input logic [67:0] actual, input logic [67:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one flit and returns 1 time unit after the edge that accepted it.
  task automatic applyStimulus(input logic head, input logic tail, input logic [31:0] data);
    int waited;
    waited = 0;
    if (gapRandom && $urandom_range(0, 2) == 0) begin
      @(posedge clk);
      #1;
    end
    flitValid = 1'b1;
    flitHead  = head;
    flitTail  = tail;
    flitData  = data;
    @(negedge clk);
    while (!flitReady) begin
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL flit_ready_timeout: got stalled %0d cycles expected accept", waited);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    flitValid = 1'b0;
    flitHead  = 1'b0;
    flitTail  = 1'b0;
  endtask

  task automatic sendHeader(input logic [3:0] dst);
    applyStimulus(1'b1, 1'b0, {28'($urandom()), dst});
  endtask

  // Beat k carries bits [32k +: 32] of {dp, cancel, dividend, divisor}; unused top bits randomized.
  task automatic sendBody(input logic [67:0] p, input int nBeats, input int tailBeat);
    logic [95:0] w;
    logic [31:0] d;
    w = {28'($urandom()), p};
    for (int k = 0; k < nBeats; k++) begin
      if (k < 3) d = w[k*32 +: 32];
      else       d = $urandom();
      applyStimulus(1'b0, (k + 1) == tailBeat, d);
    end
  endtask

  function automatic logic [67:0] randPayload();
    return {3'($urandom()), 1'($urandom()), 32'($urandom()), 32'($urandom())};
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    if (outReadyRandom) outReady = ($urandom_range(0, 2) != 0);
  end

  // Monitor: counts err pulses, checks stall stability and pops the scoreboard on each handoff.
  initial begin
    logic        stallPrev;
    logic [67:0] prevBundle;
    logic [67:0] exp;
    stallPrev  = 1'b0;
    prevBundle = '0;
    forever begin
      @(negedge clk);
      if (errO) errSeen++;
      if (stallPrev && !rst) begin
        checkOutput("stall_hold_valid", outValid, 1);
        checkOutput("stall_hold_data", bundle, prevBundle);
      end
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_delivery: got %h expected no delivery", bundle);
        end else begin
          exp = expQ.pop_front();
          checkOutput("delivery", bundle, exp);
        end
      end
      stallPrev  = outValid && !outReady && !rst;
      prevBundle = bundle;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [67:0] p, p2, p4;
    int e0, errExp, kind, k, drain;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_flit_ready", flitReady, 0);
    checkOutput("reset_outputs", bundle, 0);
    checkOutput("reset_err", errO, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_flit_ready", flitReady, 1);
    @(posedge clk);
    #1;

    $display("[TB] test 1: single request, consumer ready");
    outReady = 1'b1;
    e0 = errSeen;
    p = {3'b101, 1'b0, 32'd100, 32'd7};
    expQ.push_back(p);
    sendHeader(MY);
    sendBody(p, 3, 3);
    checkOutput("t1_latency_valid", outValid, 1);
    @(posedge clk);
    #1;
    checkOutput("t1_one_cycle", outValid, 0);
    checkOutput("t1_dp_valid_drop", dpO.valid, 0);
    checkOutput("t1_dividend_hold", dividendO, 100);
    checkOutput("t1_divisor_hold", divisorO, 7);
    checkOutput("t1_rem", dpO.rem, 1);
    waitCycles(2);
    checkOutput("t1_err", errSeen - e0, 0);

    $display("[TB] test 2: consumer stall with a waiting header");
    outReady = 1'b0;
    expQ.push_back(p);
    sendHeader(MY);
    sendBody(p, 3, 3);
    flitValid = 1'b1;
    flitHead  = 1'b1;
    flitTail  = 1'b0;
    flitData  = {28'h0, MY};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t2_stall_valid", outValid, 1);
      checkOutput("t2_flit_ready_low", flitReady, 0);
    end
    @(posedge clk);
    #1;
    p2 = {3'b011, 1'b1, 32'd555, 32'd3};
    expQ.push_back(p2);
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("t2_ready_same_cycle", flitReady, 1);
    @(posedge clk);
    #1;
    flitValid = 1'b0;
    flitHead  = 1'b0;
    checkOutput("t2_released", outValid, 0);
    sendBody(p2, 3, 3);
    waitCycles(3);
    checkOutput("t2_delivered", expQ.size(), 0);

    $display("[TB] test 3: foreign destination");
    e0 = errSeen;
    sendHeader(MY + 4'd1);
    sendBody(randPayload(), 3, 3);
    waitCycles(3);
    checkOutput("t3_err_once", errSeen - e0, 1);
    checkOutput("t3_no_valid", outValid, 0);

    $display("[TB] test 4: abort and restart");
    e0 = errSeen;
    sendHeader(MY);
    sendBody(randPayload(), 1, 0);
    p4 = {3'b110, 1'b1, 32'hFFFF_FFFF, 32'd1};
    expQ.push_back(p4);
    sendHeader(MY);
    sendBody(p4, 3, 3);
    waitCycles(3);
    checkOutput("t4_err_once", errSeen - e0, 1);
    checkOutput("t4_delivered", expQ.size(), 0);

    $display("[TB] test 5: short and long packets");
    e0 = errSeen;
    sendHeader(MY);
    sendBody(randPayload(), 2, 2);
    sendHeader(MY);
    sendBody(randPayload(), 4, 4);
    waitCycles(3);
    checkOutput("t5_err_twice", errSeen - e0, 2);
    checkOutput("t5_no_valid", outValid, 0);
    checkOutput("t5_hold_dividend", dividendO, 32'hFFFF_FFFF);

    $display("[TB] test 6: reset mid-packet");
    p = randPayload();
    sendHeader(MY);
    sendBody(p, 2, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t6_reset_outputs", bundle, 0);
    checkOutput("t6_reset_valid", outValid, 0);
    checkOutput("t6_reset_flit_ready", flitReady, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    e0 = errSeen;
    applyStimulus(1'b0, 1'b1, $urandom());
    p = randPayload();
    expQ.push_back(p);
    sendHeader(MY);
    sendBody(p, 3, 3);
    waitCycles(3);
    checkOutput("t6_stray_err", errSeen - e0, 1);
    checkOutput("t6_delivered", expQ.size(), 0);

    $display("[TB] random phase");
    gapRandom = 1'b1;
    outReadyRandom = 1'b1;
    e0 = errSeen;
    errExp = 0;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      p = randPayload();
      case (kind)
        5: begin
          errExp++;
          sendHeader(MY + 4'($urandom_range(1, 15)));
          sendBody(p, 3, 3);
        end
        6: begin
          errExp++;
          k = $urandom_range(1, 2);
          sendHeader(MY);
          sendBody(p, k, k);
        end
        7: begin
          errExp++;
          sendHeader(MY);
          sendBody(p, 4, 4);
        end
        8: begin
          errExp++;
          sendHeader(MY);
          sendBody(randPayload(), $urandom_range(0, 2), 0);
          expQ.push_back(p);
          sendHeader(MY);
          sendBody(p, 3, 3);
        end
        9: begin
          errExp++;
          if ($urandom_range(0, 1) == 0) applyStimulus(1'b0, 1'($urandom()), $urandom());
          else                           applyStimulus(1'b1, 1'b1, {28'($urandom()), MY});
        end
        default: begin
          expQ.push_back(p);
          sendHeader(MY);
          sendBody(p, 3, 3);
        end
      endcase
    end
    outReadyRandom = 1'b0;
    gapRandom = 1'b0;
    #1;
    outReady = 1'b1;
    drain = 0;
    while (expQ.size() != 0 && drain < 1000) begin
      @(posedge clk);
      drain++;
    end
    waitCycles(3);
    checkOutput("random_drain", expQ.size(), 0);
    checkOutput("random_err_total", errSeen - e0, errExp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
